// File: rtl/coin_acceptor_if.sv
// ============================================================================
//  coin_acceptor_if : coin slot / vending-side signal bundle for coin_acceptor
//  Revision 1.0
// ============================================================================
`default_nettype none

interface coin_acceptor_if #(
   parameter int AW = 2
);
   logic [1:0]  coin_in;
   logic        enable;
   logic        flush;
   logic [1:0]  deposit;
   logic [1:0]  reject;
   logic [AW:0] count;
   logic        full;
   logic        empty;
   logic        busy;

   modport master (
      output coin_in, enable, flush,
      input  deposit, reject, count, full, empty, busy
   );

   modport slave (
      input  coin_in, enable, flush,
      output deposit, reject, count, full, empty, busy
   );
endinterface

`default_nettype wire

// File: rtl/coin_acceptor.sv
// ============================================================================
//  coin_acceptor : coin FIFO between the slot and the vending controller,
//                  with bypass, overflow reject and return-lever flush
//  Revision 1.0
// ============================================================================
`default_nettype none

module coin_acceptor #(
   parameter int AW = 2
) (
   input  wire logic        clock,
   input  wire logic        reset,
   coin_acceptor_if.slave   bus
);
   localparam int           DEPTH      = 2**AW;
   localparam logic [AW:0]  FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]  CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [1:0]   COIN_NONE  = 2'd0;

   localparam logic [0:0]   ST_RUN     = 1'b0;
   localparam logic [0:0]   ST_FLUSH   = 1'b1;

   logic [1:0]    r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic [AW:0]   r_flcnt;
   logic [0:0]    r_state;
   logic [1:0]    r_deposit;
   logic [1:0]    r_reject;

   logic          w_have_coin;
   logic          w_full;
   logic          w_empty;
   logic [1:0]    w_head;
   logic          w_park_push;
   logic [1:0]    w_park_reject;

   logic          w_push;
   logic          w_pop;
   logic [1:0]    w_deposit_nxt;
   logic [1:0]    w_reject_nxt;
   logic [0:0]    w_state_nxt;
   logic [AW:0]   w_flcnt_nxt;
   logic [AW:0]   w_count_nxt;

   assign w_have_coin   = (bus.coin_in != COIN_NONE);
   assign w_full        = (r_count == FULL_COUNT);
   assign w_empty       = (r_count == '0);
   assign w_head        = r_mem[r_rd_ptr];

   // Behaviour when nothing leaves the queue: store the coin, or hand it back if no room.
   assign w_park_push   = w_have_coin && !w_full;
   assign w_park_reject = (w_have_coin && w_full) ? bus.coin_in : COIN_NONE;

   always_comb begin
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_deposit_nxt = COIN_NONE;
      w_reject_nxt  = COIN_NONE;
      w_state_nxt   = r_state;
      w_flcnt_nxt   = r_flcnt;

      case (r_state)
         ST_RUN: begin
            if (bus.flush) begin
               w_state_nxt  = ST_FLUSH;
               w_flcnt_nxt  = r_count;
               w_push       = w_park_push;
               w_reject_nxt = w_park_reject;
            end else if (bus.enable && !w_empty) begin
               // The pop frees a slot, so an arriving coin is taken even when full.
               w_pop         = 1'b1;
               w_deposit_nxt = w_head;
               w_push        = w_have_coin;
            end else if (bus.enable && w_have_coin) begin
               w_deposit_nxt = bus.coin_in;
            end else begin
               w_push       = w_park_push;
               w_reject_nxt = w_park_reject;
            end
         end

         ST_FLUSH: begin
            if (r_flcnt == '0) begin
               w_state_nxt  = ST_RUN;
               w_push       = w_park_push;
               w_reject_nxt = w_park_reject;
            end else begin
               w_pop        = 1'b1;
               w_reject_nxt = w_head;
               w_flcnt_nxt  = r_flcnt - CNT_ONE;
               w_push       = w_have_coin;
               if (r_flcnt == CNT_ONE) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end

         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_flcnt   <= '0;
         r_state   <= ST_RUN;
         r_deposit <= COIN_NONE;
         r_reject  <= COIN_NONE;
      end else begin
         r_state   <= w_state_nxt;
         r_flcnt   <= w_flcnt_nxt;
         r_count   <= w_count_nxt;
         r_deposit <= w_deposit_nxt;
         r_reject  <= w_reject_nxt;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
      end
   end

   // Storage needs no reset: contents are only read behind a valid count.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.coin_in;
      end
   end

   assign bus.deposit = r_deposit;
   assign bus.reject  = r_reject;
   assign bus.count   = r_count;
   assign bus.full    = w_full;
   assign bus.empty   = w_empty;
   assign bus.busy    = (r_state == ST_FLUSH);

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// ============================================================================
//  tb_coin_acceptor : directed and random stimulus against a queue-based model
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_coin_acceptor;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   coin_acceptor_if #(.AW(AW)) bus ();

   coin_acceptor #(.AW(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a plain queue of coins plus a "refund N more" counter.
   int         mq[$];
   bit         m_flushing;
   int         m_flrem;
   logic [1:0] exp_dep[$];
   logic [1:0] exp_rej[$];
   longint     sum_in;
   longint     sum_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input int coin, input bit en, input bit fl);
      int dep = 0;
      int rej = 0;
      bit stored = 0;
      if (coin != 0) sum_in += coin;
      if (!m_flushing && fl) begin
         m_flushing = 1;
         m_flrem    = mq.size();
      end else if (!m_flushing && en && mq.size() > 0) begin
         dep = mq.pop_front();
         if (coin != 0) begin mq.push_back(coin); stored = 1; end
      end else if (!m_flushing && en && coin != 0) begin
         dep    = coin;
         stored = 1;
      end else if (m_flushing && m_flrem > 0) begin
         rej = mq.pop_front();
         m_flrem--;
         if (m_flrem == 0) m_flushing = 0;
         if (coin != 0) begin mq.push_back(coin); stored = 1; end
      end else if (m_flushing) begin
         m_flushing = 0;
      end
      // Any coin not yet handled is queued if there is room, otherwise returned.
      if (coin != 0 && !stored && dep == 0 && rej == 0) begin
         if (mq.size() < DEPTH) mq.push_back(coin);
         else rej = coin;
      end
      if (dep != 0) exp_dep.push_back(2'(dep));
      if (rej != 0) exp_rej.push_back(2'(rej));
   endtask

   task automatic step(input int coin, input bit en, input bit fl);
      bus.coin_in = 2'(coin);
      bus.enable  = en;
      bus.flush   = fl;
      model(coin, en, fl);
      @(posedge clock);
      #1;
      check("count", bus.count, mq.size());
      check("full",  bus.full,  mq.size() == DEPTH);
      check("empty", bus.empty, mq.size() == 0);
      check("busy",  bus.busy,  m_flushing);
   endtask

   task automatic do_reset();
      bus.coin_in = 2'd0;
      bus.enable  = 1'b0;
      bus.flush   = 1'b0;
      @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("rst_deposit", bus.deposit, 0);
      check("rst_reject",  bus.reject,  0);
      check("rst_count",   bus.count,   0);
      check("rst_busy",    bus.busy,    0);
      check("rst_empty",   bus.empty,   1);
      check("rst_pending", exp_dep.size() + exp_rej.size(), 0);
      mq.delete();
      exp_dep.delete();
      exp_rej.delete();
      m_flushing = 0;
      m_flrem    = 0;
      sum_in     = 0;
      sum_out    = 0;
      #1;
      reset = 1'b0;
   endtask

   // Monitor: every coin the DUT presents must be the next one the model predicted.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.deposit != 2'd0) begin
            sum_out += bus.deposit;
            if (exp_dep.size() == 0) check("deposit_unexpected", bus.deposit, 0);
            else check("deposit", bus.deposit, exp_dep.pop_front());
         end
         if (bus.reject != 2'd0) begin
            sum_out += bus.reject;
            if (exp_rej.size() == 0) check("reject_unexpected", bus.reject, 0);
            else check("reject", bus.reject, exp_rej.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      bus.coin_in = 2'd0;
      bus.enable  = 1'b0;
      bus.flush   = 1'b0;
      repeat (2) @(posedge clock);
      do_reset();

      // Bypass: empty queue, enabled controller, coin straight through.
      step(2, 1, 0);
      check("t1_deposit", bus.deposit, 2);
      check("t1_count", bus.count, 0);

      // Fill the queue, then overflow.
      step(1, 0, 0); step(2, 0, 0); step(3, 0, 0); step(1, 0, 0);
      check("t2_full", bus.full, 1);
      step(3, 0, 0);
      check("t2_reject", bus.reject, 3);
      check("t2_count", bus.count, 4);

      // Drain in order.
      step(0, 1, 0); check("t3_d0", bus.deposit, 1);
      step(0, 1, 0); check("t3_d1", bus.deposit, 2);
      step(0, 1, 0); check("t3_d2", bus.deposit, 3);
      step(0, 1, 0); check("t3_d3", bus.deposit, 1);
      step(0, 1, 0); check("t3_idle", bus.deposit, 0);
      check("t3_empty", bus.empty, 1);

      // Full queue, pop and push on the same edge.
      step(3, 0, 0); step(1, 0, 0); step(1, 0, 0); step(2, 0, 0);
      step(2, 1, 0);
      check("t4_deposit", bus.deposit, 3);
      check("t4_reject", bus.reject, 0);
      check("t4_count", bus.count, 4);
      repeat (5) step(0, 1, 0);

      // Flush with a coin arriving on the flush edge.
      step(1, 0, 0); step(2, 0, 0);
      step(3, 0, 1);
      check("t5_busy", bus.busy, 1);
      step(0, 1, 0);
      check("t5_rej0", bus.reject, 1);
      check("t5_dep0", bus.deposit, 0);
      step(0, 1, 0);
      check("t5_rej1", bus.reject, 2);
      check("t5_count", bus.count, 1);
      check("t5_busy_end", bus.busy, 0);
      repeat (2) step(0, 1, 0);

      // Reset during a flush.
      step(1, 0, 0); step(2, 0, 0); step(3, 0, 0);
      step(0, 0, 1);
      step(0, 1, 0);
      check("t6_busy_before", bus.busy, 1);
      do_reset();

      // Random traffic in phases with varying drain rate.
      for (int ph = 0; ph < 12; ph++) begin
         int en_pct;
         en_pct = $urandom_range(0, 100);
         for (int i = 0; i < 250; i++) begin
            step($urandom_range(0, 3), ($urandom_range(0, 99) < en_pct), ($urandom_range(0, 19) == 0));
         end
      end
      repeat (DEPTH + 4) step(0, 1, 0);
      @(negedge clock);
      #1;
      check("final_count", bus.count, 0);
      check("final_pending", exp_dep.size() + exp_rej.size(), 0);
      check("conservation", 32'(sum_out), 32'(sum_in));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
